// File: rtl/mux_pkg.sv
// mux_pkg: shared lane count, slot width, FSM states and mode encodings for the TDM demux
package mux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = $clog2(LANES);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic MODE_TDM = 1'b0;
  localparam logic MODE_ADDR = 1'b1;
endpackage

// File: rtl/demux_1_to_8_tdm_if.sv
// demux_1_to_8_tdm_if: beat input and parallel lane output bundle of the TDM demux
interface demux_1_to_8_tdm_if #(parameter int WIDTH = 1);
  import mux_pkg::*;
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic sof;
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [LANES*WIDTH-1:0] dout;
  logic dout_valid;
  logic [SEL_W-1:0] slot;
  logic err_sof;
  modport master (output din, din_valid, sof, mode, sel, input dout, dout_valid, slot, err_sof);
  modport slave (input din, din_valid, sof, mode, sel, output dout, dout_valid, slot, err_sof);
endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot counter with clear, load-to-1, increment and last-slot flag
module tdm_slot_counter
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_slot,
  output logic             o_wrap
);
  logic [SEL_W-1:0] r_slot;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_slot <= '0;
    else if (i_load1) r_slot <= SEL_W'(1);
    else if (i_inc) r_slot <= r_slot + 1'b1;
  end
  assign o_slot = r_slot;
  assign o_wrap = r_slot == SEL_W'(LANES - 1);
endmodule

// File: rtl/demux_1_to_8_tdm.sv
// demux_1_to_8_tdm: 1-lane TDM stream to 8 registered lanes, with an addressed single-lane write mode
module demux_1_to_8_tdm
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst,
  demux_1_to_8_tdm_if.slave bus
);
  state_t r_state;
  logic [(LANES-1)*WIDTH-1:0] r_accum;
  logic [LANES*WIDTH-1:0] r_dout;
  logic r_dout_valid;
  logic r_err_sof;
  logic [SEL_W-1:0] w_slot;
  logic w_wrap, w_tdm, w_fill, w_sof, w_data, w_done, w_inc, w_addr_wr;
  assign w_tdm = bus.mode == MODE_TDM;
  assign w_fill = r_state == FILL;
  assign w_sof = w_tdm & bus.din_valid & bus.sof;
  assign w_data = w_tdm & bus.din_valid & ~bus.sof & w_fill;
  assign w_done = w_data & w_wrap;
  assign w_inc = w_data & ~w_wrap;
  assign w_addr_wr = ~w_tdm & bus.din_valid;
  tdm_slot_counter u_slot (
    .clk(clk),
    .rst(rst),
    .i_clr(~w_tdm | w_done),
    .i_load1(w_sof),
    .i_inc(w_inc),
    .o_slot(w_slot),
    .o_wrap(w_wrap)
  );
  // lane 7 of a frame goes straight to dout, so accum only holds lanes 0..6
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_accum <= '0;
      r_dout <= '0;
      r_dout_valid <= 1'b0;
      r_err_sof <= 1'b0;
    end else begin
      r_state <= (~w_tdm | w_done) ? IDLE : w_sof ? FILL : r_state;
      r_dout_valid <= w_done | w_addr_wr;
      r_err_sof <= w_sof & w_fill;
      if (w_sof) r_accum[0 +: WIDTH] <= bus.din;
      if (w_inc) r_accum[int'(w_slot)*WIDTH +: WIDTH] <= bus.din;
      if (w_done) r_dout <= {bus.din, r_accum};
      else if (w_addr_wr) r_dout[int'(bus.sel)*WIDTH +: WIDTH] <= bus.din;
    end
  end
  assign bus.dout = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.slot = w_slot;
  assign bus.err_sof = r_err_sof;
endmodule

// File: tb/tb_demux_1_to_8_tdm.sv
// tb_demux_1_to_8_tdm: directed and random stimulus checked against a frame-queue model of the demux
module tb_demux_1_to_8_tdm;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_dout;
  logic m_dv, m_err;
  bit in_frame;
  bit q[$];
  demux_1_to_8_tdm_if #(.WIDTH(1)) bus ();
  demux_1_to_8_tdm #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic s, input logic m, input logic [2:0] sl, input logic d);
    rst = r;
    bus.din_valid = v;
    bus.sof = s;
    bus.mode = m;
    bus.sel = sl;
    bus.din = d;
    @(posedge clk);
    #1;
    m_dv = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_dout = '0;
      in_frame = 0;
      q.delete();
    end else if (m) begin
      in_frame = 0;
      q.delete();
      if (v) begin
        m_dout[sl] = d;
        m_dv = 1'b1;
      end
    end else if (v) begin
      if (s) begin
        m_err = in_frame;
        q.delete();
        q.push_back(d);
        in_frame = 1;
      end else if (in_frame) begin
        q.push_back(d);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) m_dout[i] = q[i];
          m_dv = 1'b1;
          in_frame = 0;
          q.delete();
        end
      end
    end
    chk("dout", 32'(bus.dout), 32'(m_dout));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    chk("err_sof", 32'(bus.err_sof), 32'(m_err));
    chk("slot", 32'(bus.slot), in_frame ? q.size() : 0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic frame(input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, i == 0, 0, 0, w[i]);
      if (i != 7) repeat (gap) idle();
    end
    chk("frame_word", 32'(bus.dout), 32'(w));
    chk("frame_valid", 32'(bus.dout_valid), 1);
    chk("frame_slot", 32'(bus.slot), 0);
  endtask
  initial begin
    m_dout = '0;
    step(1, 0, 0, 0, 0, 0);
    chk("reset_dout", 32'(bus.dout), 0);
    chk("reset_slot", 32'(bus.slot), 0);
    frame(8'h4D, 0);
    idle();
    chk("valid_one_cycle", 32'(bus.dout_valid), 0);
    step(1, 0, 0, 0, 0, 0);
    frame(8'h4D, 2);
    idle();
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("early_sof_err", 32'(bus.err_sof), 1);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 1);
    chk("early_sof_word", 32'(bus.dout), 32'h FE);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 3'd5, 1);
    chk("addr_sel5", 32'(bus.dout), 32'h20);
    step(0, 1, 0, 1, 3'd2, 1);
    chk("addr_sel2", 32'(bus.dout), 32'h24);
    chk("addr_valid", 32'(bus.dout_valid), 1);
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("midreset_dout", 32'(bus.dout), 0);
    chk("midreset_slot", 32'(bus.slot), 0);
    frame(8'hA5, 0);
    for (int i = 0; i < 5; i++) step(0, 1, i == 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("switch_slot", 32'(bus.slot), 0);
    chk("switch_err", 32'(bus.err_sof), 0);
    frame(8'h3C, 0);
    frame(8'h96, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 2, ($urandom % 4) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, 3'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
